// File: rtl/port_rd_backend.sv
// Read-side ECC backend: buffers one page (1-8 x 16-bit words), checks it against its
// 8-bit Hamming code, corrects single-bit errors and streams the words out.
module port_rd_backend (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vld,
    input  logic [15:0] in_data,
    input  logic        in_last,
    input  logic [7:0]  in_code,
    output logic        in_rdy,
    output logic        out_vld,
    output logic [15:0] out_data,
    output logic        out_last,
    input  logic        out_rdy,
    output logic        ecc_corr,
    output logic        ecc_uncorr,
    output logic [15:0] corr_cnt,
    output logic [15:0] uncorr_cnt
);

    typedef enum logic [1:0] {FILL, CHECK, DRAIN} state_t;

    state_t      state;
    logic [15:0] page [8];
    logic [2:0]  cnt;
    logic [3:0]  len;
    logic [2:0]  rd_idx;
    logic [7:0]  code_r;

    logic [127:0] data_flat;
    logic [127:0] fixed_flat;
    logic [7:0]   calc;
    logic [7:0]   syn;
    logic         hit_corr;
    logic         hit_uncorr;

    // Hamming position of data bit i: skip 1,2 via the +3 offset, then step over each
    // power of two the running position reaches.
    function automatic logic [7:0] ham_pos(input int unsigned i);
        int unsigned p;
        p = i + 3;
        for (int unsigned b = 2; b < 8; b++) begin
            if (p >= (32'd1 << b)) p = p + 1;
        end
        return 8'(p);
    endfunction

    always_comb begin
        data_flat = '0;
        for (int unsigned k = 0; k < 8; k++) data_flat[16*k +: 16] = page[k];
        calc = '0;
        for (int unsigned i = 0; i < 128; i++) begin
            if (data_flat[i]) calc = calc ^ ham_pos(i);
        end
        syn        = code_r ^ calc;
        fixed_flat = data_flat;
        hit_corr   = 1'b0;
        hit_uncorr = 1'b0;
        if (syn != 8'd0) begin
            if ((syn & (syn - 8'd1)) == 8'd0) begin
                hit_corr = 1'b1;
            end else if (syn > 8'd136) begin
                hit_uncorr = 1'b1;
            end else begin
                for (int unsigned i = 0; i < 128; i++) begin
                    if (ham_pos(i) == syn) begin
                        if ((i >> 4) < 32'(len)) begin
                            fixed_flat[i] = ~data_flat[i];
                            hit_corr      = 1'b1;
                        end else begin
                            hit_uncorr = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            for (int unsigned k = 0; k < 8; k++) page[k] <= '0;
            cnt        <= '0;
            len        <= '0;
            rd_idx     <= '0;
            code_r     <= '0;
            in_rdy     <= 1'b1;
            out_vld    <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            ecc_corr   <= 1'b0;
            ecc_uncorr <= 1'b0;
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            ecc_corr   <= 1'b0;
            ecc_uncorr <= 1'b0;
            case (state)
                FILL: begin
                    if (in_vld) begin
                        page[cnt] <= in_data;
                        if (in_last || cnt == 3'd7) begin
                            len    <= {1'b0, cnt} + 4'd1;
                            code_r <= in_code;
                            in_rdy <= 1'b0;
                            state  <= CHECK;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                CHECK: begin
                    for (int unsigned k = 0; k < 8; k++) page[k] <= fixed_flat[16*k +: 16];
                    out_data   <= fixed_flat[15:0];
                    out_vld    <= 1'b1;
                    out_last   <= (len == 4'd1);
                    rd_idx     <= '0;
                    ecc_corr   <= hit_corr;
                    ecc_uncorr <= hit_uncorr;
                    if (hit_corr && corr_cnt != 16'hFFFF) corr_cnt <= corr_cnt + 16'd1;
                    if (hit_uncorr && uncorr_cnt != 16'hFFFF) uncorr_cnt <= uncorr_cnt + 16'd1;
                    state      <= DRAIN;
                end
                DRAIN: begin
                    if (out_rdy) begin
                        if ({1'b0, rd_idx} == len - 4'd1) begin
                            // Clearing here leaves unreceived words zero for the next page.
                            for (int unsigned k = 0; k < 8; k++) page[k] <= '0;
                            out_vld  <= 1'b0;
                            out_last <= 1'b0;
                            out_data <= '0;
                            cnt      <= '0;
                            in_rdy   <= 1'b1;
                            state    <= FILL;
                        end else begin
                            rd_idx   <= rd_idx + 3'd1;
                            out_data <= page[rd_idx + 3'd1];
                            out_last <= ({1'b0, rd_idx} + 4'd1 == len - 4'd1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
